// File: rtl/pixel_pkg.sv
// Shared constants, state encoding and modulo-DEPTH helper for the pixel span writer.
// PIXEL_RECT_EN selects rectangle fills in the files that import this package.
package pixel_pkg;

  localparam int unsigned SCREEN_WIDTH  = 32'd640;
  localparam int unsigned SCREEN_HEIGHT = 32'd480;
  localparam int unsigned DEPTH         = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam int unsigned LINE_PIXELS   = SCREEN_WIDTH;
  localparam int unsigned ADDRESS_WIDTH = 32'd19;
  localparam int unsigned LEN_WIDTH     = 32'd19;

  // One extra bit so a sum can be compared against DEPTH before wrapping.
  localparam logic [ADDRESS_WIDTH:0] DEPTH_EXT  = DEPTH[ADDRESS_WIDTH:0];
  localparam logic [ADDRESS_WIDTH:0] STRIDE_EXT = LINE_PIXELS[ADDRESS_WIDTH:0];
  localparam logic [LEN_WIDTH-1:0]   LEN_ZERO   = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0]   LEN_ONE    = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ADDR_HOLD = 2'd0,
    ADDR_LOAD = 2'd1,
    ADDR_INC  = 2'd2,
    ADDR_ROW  = 2'd3
  } addr_op_e;

  // Valid for any value below 2*DEPTH, which covers every raw address and every sum used here.
  function automatic logic [ADDRESS_WIDTH-1:0] wrap_addr(input logic [ADDRESS_WIDTH:0] a);
    logic [ADDRESS_WIDTH:0] r;
    if (a >= DEPTH_EXT) begin
      r = a - DEPTH_EXT;
    end else begin
      r = a;
    end
    return r[ADDRESS_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/pixel_addr_wrap.sv
// Registered pixel address counter: load, +1, and (with PIXEL_RECT_EN) +LINE_PIXELS row step,
// all modulo DEPTH.
module pixel_addr_wrap
  import pixel_pkg::*;
(
  input  logic                     clk,
  input  logic                     resetn,
  input  addr_op_e                 op,
  input  logic [ADDRESS_WIDTH-1:0] load_addr,
  output logic [ADDRESS_WIDTH-1:0] addr
);

  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
`ifdef PIXEL_RECT_EN
  logic [ADDRESS_WIDTH-1:0] base_q, base_d;
`endif

  // Next address; a row step restarts from the previous row base, not from the current pixel.
  always_comb begin
    addr_d = addr_q;
`ifdef PIXEL_RECT_EN
    base_d = base_q;
`endif
    case (op)
      ADDR_LOAD: begin
        addr_d = wrap_addr({1'b0, load_addr});
`ifdef PIXEL_RECT_EN
        base_d = wrap_addr({1'b0, load_addr});
`endif
      end
      ADDR_INC: begin
        addr_d = wrap_addr({1'b0, addr_q} + {{ADDRESS_WIDTH{1'b0}}, 1'b1});
      end
`ifdef PIXEL_RECT_EN
      ADDR_ROW: begin
        base_d = wrap_addr({1'b0, base_q} + STRIDE_EXT);
        addr_d = wrap_addr({1'b0, base_q} + STRIDE_EXT);
      end
`endif
      default: begin
        addr_d = addr_q;
      end
    endcase
  end

  // Address (and row base) registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q <= {ADDRESS_WIDTH{1'b0}};
`ifdef PIXEL_RECT_EN
      base_q <= {ADDRESS_WIDTH{1'b0}};
`endif
    end else begin
      addr_q <= addr_d;
`ifdef PIXEL_RECT_EN
      base_q <= base_d;
`endif
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/pixel_span_writer.sv
// Fill engine streaming one pixel write per clock into frame-buffer port 0.
// Define PIXEL_RECT_EN for rows x length rectangle fills (adds the rows port).
module pixel_span_writer
  import pixel_pkg::*;
(
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]     length,
  input  logic                     color,
  input  logic                     abort,
`ifdef PIXEL_RECT_EN
  input  logic [LEN_WIDTH-1:0]     rows,
`endif
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] pixelAddr,
  output logic                     pixelIn,
  output logic                     pixelWe
);

  state_e                 state_q;
  logic [LEN_WIDTH-1:0]   col_q;
  logic                   color_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   we_q;
`ifdef PIXEL_RECT_EN
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   rows_q;
`endif

  logic     accept_s;
  logic     empty_cmd_s;
  logic     last_col_s;
  logic     last_row_s;
  addr_op_e addr_op_s;

  // Command acceptance and end-of-span/row decode; abort overrides start.
  always_comb begin
    accept_s   = (state_q == IDLE) && start && !abort;
    last_col_s = (col_q == LEN_ONE);
`ifdef PIXEL_RECT_EN
    empty_cmd_s = (length == LEN_ZERO) || (rows == LEN_ZERO);
    last_row_s  = (rows_q == LEN_ONE);
`else
    empty_cmd_s = (length == LEN_ZERO);
    last_row_s  = 1'b1;
`endif
  end

  // Address counter operation for the coming edge.
  always_comb begin
    addr_op_s = ADDR_HOLD;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          addr_op_s = ADDR_LOAD;
        end else begin
          addr_op_s = ADDR_HOLD;
        end
      end
      WRITE: begin
        if (abort) begin
          addr_op_s = ADDR_HOLD;
        end else if (!last_col_s) begin
          addr_op_s = ADDR_INC;
        end else if (!last_row_s) begin
          addr_op_s = ADDR_ROW;
        end else begin
          addr_op_s = ADDR_HOLD;
        end
      end
      default: begin
        addr_op_s = ADDR_HOLD;
      end
    endcase
  end

  pixel_addr_wrap u_addr (
    .clk       (clk),
    .resetn    (resetn),
    .op        (addr_op_s),
    .load_addr (start_addr),
    .addr      (pixelAddr)
  );

  // Control FSM with command latches, span/row counters and registered strobes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      col_q   <= LEN_ZERO;
      color_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
`ifdef PIXEL_RECT_EN
      len_q   <= LEN_ZERO;
      rows_q  <= LEN_ZERO;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (accept_s) begin
            color_q <= color;
            col_q   <= length;
            busy_q  <= 1'b1;
`ifdef PIXEL_RECT_EN
            len_q   <= length;
            rows_q  <= rows;
`endif
            if (empty_cmd_s) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              we_q    <= 1'b0;
            end else begin
              state_q <= WRITE;
              we_q    <= 1'b1;
            end
          end else begin
            busy_q <= 1'b0;
            we_q   <= 1'b0;
          end
        end
        WRITE: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
          end else if (last_col_s && last_row_s) begin
            state_q <= DONE;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
          end else if (last_col_s) begin
`ifdef PIXEL_RECT_EN
            col_q  <= len_q;
            rows_q <= rows_q - LEN_ONE;
`else
            col_q  <= col_q;
`endif
          end else begin
            col_q <= col_q - LEN_ONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          we_q    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign pixelWe = we_q;
  assign pixelIn = color_q;

endmodule

// File: tb/tb_pixel_span_writer.sv
// Randomized self-checking bench for pixel_span_writer against an arithmetic address model.
// Exercises rectangle fills too when PIXEL_RECT_EN is defined.
module tb_pixel_span_writer;

  localparam int unsigned TB_DEPTH = 307200;
  localparam int unsigned TB_LINE  = 640;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [18:0] start_addr;
  logic [18:0] length;
  logic        color;
  logic        abort;
`ifdef PIXEL_RECT_EN
  logic [18:0] rows;
`endif
  logic        busy;
  logic        done;
  logic [18:0] pixelAddr;
  logic        pixelIn;
  logic        pixelWe;

  int unsigned vectors;
  int unsigned miscompares;

  pixel_span_writer dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .color      (color),
    .abort      (abort),
`ifdef PIXEL_RECT_EN
    .rows       (rows),
`endif
    .busy       (busy),
    .done       (done),
    .pixelAddr  (pixelAddr),
    .pixelIn    (pixelIn),
    .pixelWe    (pixelWe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_we"}, 32'(pixelWe), 32'd0);
  endtask

  // Called just after a clock edge; leaves the bench just after an edge with the engine idle.
  task automatic run_cmd(input int unsigned a, input int unsigned len, input int unsigned nr,
                         input bit col, input int unsigned abort_at, input bit busy_start);
    int unsigned eff_rows;
    int unsigned total;
    int unsigned exp_addr;
`ifdef PIXEL_RECT_EN
    eff_rows = nr;
    rows     = nr[18:0];
`else
    eff_rows = 1;
`endif
    total      = len * eff_rows;
    start_addr = a[18:0];
    length     = len[18:0];
    color      = col;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    start_addr = 19'($urandom);
    color      = ~col;
    for (int k = 0; k < int'(total); k++) begin
      exp_addr = ((a % TB_DEPTH) + (32'(k) / len) * TB_LINE + (32'(k) % len)) % TB_DEPTH;
      check("we", 32'(pixelWe), 32'd1);
      check("addr", 32'(pixelAddr), exp_addr);
      check("pixel", 32'(pixelIn), 32'(col));
      check("busy_wr", 32'(busy), 32'd1);
      check("done_wr", 32'(done), 32'd0);
      if (busy_start && k == 0) begin
        start      = 1'b1;
        length     = 19'($urandom_range(1, 30));
        start_addr = 19'($urandom);
      end else begin
        start = 1'b0;
      end
      if (abort_at != 0 && 32'(k) + 1 == abort_at) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        check_idle("abort");
        return;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("done_pulse", 32'(done), 32'd1);
    check("busy_done", 32'(busy), 32'd1);
    check("we_done", 32'(pixelWe), 32'd0);
    @(posedge clk); #1;
    check_idle("after");
  endtask

  initial begin
    int unsigned a;
    int unsigned len;
    int unsigned nr;
    int unsigned ab;
    vectors     = 0;
    miscompares = 0;
    resetn      = 1'b0;
    start       = 1'b0;
    start_addr  = 19'd0;
    length      = 19'd0;
    color       = 1'b0;
    abort       = 1'b0;
`ifdef PIXEL_RECT_EN
    rows        = 19'd0;
`endif
    #1;
    check_idle("reset");
    check("reset_addr", 32'(pixelAddr), 32'd0);
    check("reset_pixel", 32'(pixelIn), 32'd0);
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    @(posedge clk); #1;

    run_cmd(100, 5, 1, 1'b1, 0, 1'b0);
    run_cmd(307198, 4, 1, 1'b0, 0, 1'b0);
    run_cmd(555, 0, 1, 1'b1, 0, 1'b0);
    run_cmd(2000, 10, 1, 1'b1, 3, 1'b0);
    run_cmd(3000, 6, 1, 1'b1, 0, 1'b1);
    run_cmd(500000, 3, 1, 1'b1, 0, 1'b0);
`ifdef PIXEL_RECT_EN
    run_cmd(641, 3, 2, 1'b1, 0, 1'b0);
    run_cmd(306900, 700, 1, 1'b0, 0, 1'b0);
    run_cmd(306600, 4, 3, 1'b1, 0, 1'b0);
    run_cmd(10, 5, 0, 1'b1, 0, 1'b0);
`endif

    // start together with abort in IDLE must not be accepted
    start  = 1'b1;
    abort  = 1'b1;
    length = 19'd4;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check_idle("abort_start");
    @(posedge clk); #1;
    check_idle("abort_start2");

    // reset dropped mid-span clears outputs without waiting for a clock
    start_addr = 19'd1234;
    length     = 19'd8;
    color      = 1'b1;
`ifdef PIXEL_RECT_EN
    rows       = 19'd1;
`endif
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check_idle("async_rst");
    check("async_rst_addr", 32'(pixelAddr), 32'd0);
    check("async_rst_pixel", 32'(pixelIn), 32'd0);
    @(posedge clk);
    #2 resetn = 1'b1;
    @(posedge clk); #1;
    check_idle("post_rst");
    @(posedge clk); #1;
    check_idle("post_rst2");

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        a = $urandom_range(307185, 307199);
      end else begin
        a = $urandom_range(0, 524287);
      end
      len = $urandom_range(0, 12);
      nr  = $urandom_range(0, 3);
      ab  = 0;
      if ($urandom_range(0, 3) == 0 && len != 0) begin
        ab = $urandom_range(1, len);
      end
      run_cmd(a, len, nr, 1'($urandom), ab, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
